// File: rtl/alu_instr_encoder_if.sv
// rtl/alu_instr_encoder_if.sv - request and instruction-memory write bus for alu_instr_encoder
interface alu_instr_encoder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            alu_function;
    logic                  is_imm;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [11:0]           imm;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;

    modport master (
        output in_valid, alu_function, is_imm, rd, rs1, rs2, imm, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, alu_function, is_imm, rd, rs1, rs2, imm, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/alu_instr_encoder.sv
// rtl/alu_instr_encoder.sv - encodes ALU requests into RV32I words and writes them to instruction memory
module alu_instr_encoder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    COUNT_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_instr_encoder_if.slave     bus,
    input  logic                   load_base,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] written_count,
    output logic [COUNT_WIDTH-1:0] illegal_count
);
    typedef enum logic {IDLE, WRITE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  mem_we_q;
    logic [31:0]           mem_wdata_q;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic                  legal;
    logic [31:0]           word;

    assign bus.in_ready  = (state == IDLE) && !load_base;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = mem_wdata_q;

    // xor only exists as xori, sub only as an R-type; everything else maps 1:1
    always_comb begin
        f3    = 3'b000;
        f7    = 7'b0000000;
        legal = 1'b1;
        if (bus.is_imm) begin
            case (bus.alu_function)
                3'b000:  f3 = 3'b000;
                3'b010:  f3 = 3'b111;
                3'b011:  f3 = 3'b110;
                3'b100:  f3 = 3'b010;
                3'b101:  f3 = 3'b100;
                default: legal = 1'b0;
            endcase
        end else begin
            case (bus.alu_function)
                3'b000:  f3 = 3'b000;
                3'b001:  f7 = 7'b0100000;
                3'b010:  f3 = 3'b111;
                3'b011:  f3 = 3'b110;
                3'b100:  f3 = 3'b010;
                default: legal = 1'b0;
            endcase
        end
        word = bus.is_imm ? {bus.imm, bus.rs1, f3, bus.rd, 7'b0010011}
                          : {f7, bus.rs2, bus.rs1, f3, bus.rd, 7'b0110011};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= RESET_ADDR;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            illegal       <= 1'b0;
            written_count <= '0;
            illegal_count <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_base) begin
                        addr <= base_addr;
                    end else if (bus.in_valid) begin
                        if (legal) begin
                            mem_wdata_q <= word;
                            mem_we_q    <= 1'b1;
                            state       <= WRITE;
                        end else begin
                            illegal <= 1'b1;
                            if (!(&illegal_count))
                                illegal_count <= illegal_count + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        mem_we_q <= 1'b0;
                        state    <= IDLE;
                        addr     <= addr + ADDR_WIDTH'(4);
                        if (!(&written_count))
                            written_count <= written_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_instr_encoder.sv
// tb/tb_alu_instr_encoder.sv - randomized self-checking bench for alu_instr_encoder
module tb_alu_instr_encoder;
    logic clk = 1'b0;
    logic rst1, rst2;
    logic load_base1, load_base2;
    logic [31:0] base1;
    logic [7:0]  base2;
    logic illegal1, illegal2;
    logic [15:0] wcnt1, icnt1;
    logic [2:0]  wcnt2, icnt2;

    int total = 0;
    int bad = 0;

    logic [31:0] m_addr;
    int m_wr, m_il;

    alu_instr_encoder_if #(.ADDR_WIDTH(32)) bus1 ();
    alu_instr_encoder_if #(.ADDR_WIDTH(8))  bus2 ();

    alu_instr_encoder #(.ADDR_WIDTH(32), .COUNT_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1.slave), .load_base(load_base1), .base_addr(base1),
        .illegal(illegal1), .written_count(wcnt1), .illegal_count(icnt1)
    );

    alu_instr_encoder #(.ADDR_WIDTH(8), .COUNT_WIDTH(3)) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2.slave), .load_base(load_base2), .base_addr(base2),
        .illegal(illegal2), .written_count(wcnt2), .illegal_count(icnt2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder: instruction tables indexed by alu_function, word assembled arithmetically
    function automatic void ref_encode(input logic [2:0] fn, input logic ii, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im,
                                       output bit ok, output logic [31:0] w);
        int r_f3 [8] = '{0, 0, 7, 6, 2, 0, 0, 0};
        int r_f7 [8] = '{0, 32, 0, 0, 0, 0, 0, 0};
        bit r_ok [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        int i_f3 [8] = '{0, 0, 7, 6, 2, 4, 0, 0};
        bit i_ok [8] = '{1, 0, 1, 1, 1, 1, 0, 0};
        longint unsigned v;
        if (ii) begin
            ok = i_ok[fn];
            v = longint'(im) * (2**20) + longint'(s1) * (2**15) + longint'(i_f3[fn]) * (2**12)
                + longint'(d) * (2**7) + 19;
        end else begin
            ok = r_ok[fn];
            v = longint'(r_f7[fn]) * (2**25) + longint'(s2) * (2**20) + longint'(s1) * (2**15)
                + longint'(r_f3[fn]) * (2**12) + longint'(d) * (2**7) + 51;
        end
        w = v[31:0];
    endfunction

    task automatic set_req(input logic [2:0] fn, input logic ii, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im);
        bus1.alu_function = fn; bus1.is_imm = ii; bus1.rd = d; bus1.rs1 = s1; bus1.rs2 = s2; bus1.imm = im;
        bus2.alu_function = fn; bus2.is_imm = ii; bus2.rd = d; bus2.rs1 = s1; bus2.rs2 = s2; bus2.imm = im;
    endtask

    task automatic test_reset();
        rst1 = 1; rst2 = 1;
        step(); step();
        rst1 = 0; rst2 = 0;
        #1;
        total++; if (bus1.mem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %0h want 0", bus1.mem_we); end
        total++; if (bus1.mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", bus1.mem_wdata); end
        total++; if (bus1.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus1.mem_addr); end
        total++; if (illegal1 !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %0h want 0", illegal1); end
        total++; if (wcnt1 !== 16'd0 || icnt1 !== 16'd0) begin bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", wcnt1, icnt1); end
        total++; if (bus1.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0h want 1", bus1.in_ready); end
        m_addr = 0; m_wr = 0; m_il = 0;
    endtask

    task automatic test_load_and_add();
        set_req(3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0);
        load_base1 = 1; base1 = 32'h100; bus1.in_valid = 1;
        #1;
        total++; if (bus1.in_ready !== 1'b0) begin bad++; $display("FAIL load_ready: got %0h want 0", bus1.in_ready); end
        step();
        load_base1 = 0;
        #1;
        total++; if (bus1.mem_we !== 1'b0 || bus1.mem_addr !== 32'h100) begin bad++; $display("FAIL load_base: got we=%0h addr=%h want we=0 addr=100", bus1.mem_we, bus1.mem_addr); end
        total++; if (bus1.in_ready !== 1'b1) begin bad++; $display("FAIL load_ready_after: got %0h want 1", bus1.in_ready); end
        step();
        bus1.in_valid = 0;
        total++; if (bus1.mem_we !== 1'b1 || bus1.mem_addr !== 32'h100 || bus1.mem_wdata !== 32'h002081B3) begin
            bad++; $display("FAIL add_write: got we=%0h addr=%h data=%h want we=1 addr=100 data=002081b3", bus1.mem_we, bus1.mem_addr, bus1.mem_wdata); end
        total++; if (bus1.in_ready !== 1'b0) begin bad++; $display("FAIL add_ready: got %0h want 0", bus1.in_ready); end
        bus1.mem_ack = 1;
        step();
        bus1.mem_ack = 0;
        total++; if (bus1.mem_we !== 1'b0 || wcnt1 !== 16'd1 || bus1.mem_addr !== 32'h104) begin
            bad++; $display("FAIL add_done: got we=%0h cnt=%0d addr=%h want we=0 cnt=1 addr=104", bus1.mem_we, wcnt1, bus1.mem_addr); end
        m_addr = 32'h104; m_wr = 1;
    endtask

    task automatic test_back_to_back();
        set_req(3'b001, 1'b0, 5'd5, 5'd6, 5'd7, 12'h0);
        bus1.in_valid = 1; bus1.mem_ack = 1;
        step();
        total++; if (bus1.mem_we !== 1'b1 || bus1.mem_addr !== 32'h104 || bus1.mem_wdata !== 32'h407302B3) begin
            bad++; $display("FAIL b2b_sub: got we=%0h addr=%h data=%h want we=1 addr=104 data=407302b3", bus1.mem_we, bus1.mem_addr, bus1.mem_wdata); end
        total++; if (bus1.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready1: got %0h want 0", bus1.in_ready); end
        set_req(3'b000, 1'b1, 5'd1, 5'd0, 5'd0, 12'd5);
        step();
        total++; if (bus1.mem_we !== 1'b0 || bus1.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_gap: got we=%0h ready=%0h want we=0 ready=1", bus1.mem_we, bus1.in_ready); end
        step();
        bus1.in_valid = 0;
        total++; if (bus1.mem_we !== 1'b1 || bus1.mem_addr !== 32'h108 || bus1.mem_wdata !== 32'h00500093) begin
            bad++; $display("FAIL b2b_addi: got we=%0h addr=%h data=%h want we=1 addr=108 data=00500093", bus1.mem_we, bus1.mem_addr, bus1.mem_wdata); end
        total++; if (bus1.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready2: got %0h want 0", bus1.in_ready); end
        step();
        bus1.mem_ack = 0;
        total++; if (wcnt1 !== 16'd3 || bus1.mem_addr !== 32'h10C) begin bad++; $display("FAIL b2b_done: got cnt=%0d addr=%h want cnt=3 addr=10c", wcnt1, bus1.mem_addr); end
        m_addr = 32'h10C; m_wr = 3;
    endtask

    task automatic test_stall();
        set_req(3'b101, 1'b1, 5'd2, 5'd1, 5'd0, 12'hFFF);
        bus1.in_valid = 1;
        step();
        bus1.in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            total++; if (bus1.mem_we !== 1'b1 || bus1.mem_addr !== 32'h10C || bus1.mem_wdata !== 32'hFFF0C113) begin
                bad++; $display("FAIL stall_hold%0d: got we=%0h addr=%h data=%h want we=1 addr=10c data=fff0c113", i, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata); end
            step();
        end
        total++; if (bus1.mem_we !== 1'b1 || wcnt1 !== 16'd3) begin bad++; $display("FAIL stall_pending: got we=%0h cnt=%0d want we=1 cnt=3", bus1.mem_we, wcnt1); end
        bus1.mem_ack = 1;
        step();
        bus1.mem_ack = 0;
        total++; if (bus1.mem_we !== 1'b0 || wcnt1 !== 16'd4 || bus1.mem_addr !== 32'h110) begin
            bad++; $display("FAIL stall_done: got we=%0h cnt=%0d addr=%h want we=0 cnt=4 addr=110", bus1.mem_we, wcnt1, bus1.mem_addr); end
        m_addr = 32'h110; m_wr = 4;
    endtask

    task automatic test_illegal();
        logic [2:0] fns [3] = '{3'b101, 3'b001, 3'b111};
        logic       imms [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            set_req(fns[i], imms[i], 5'd9, 5'd10, 5'd11, 12'h123);
            bus1.in_valid = 1;
            step();
            bus1.in_valid = 0;
            total++; if (illegal1 !== 1'b1 || bus1.mem_we !== 1'b0) begin bad++; $display("FAIL illegal_pulse%0d: got ill=%0h we=%0h want ill=1 we=0", i, illegal1, bus1.mem_we); end
            step();
            total++; if (illegal1 !== 1'b0 || bus1.mem_we !== 1'b0) begin bad++; $display("FAIL illegal_clear%0d: got ill=%0h we=%0h want 0 0", i, illegal1, bus1.mem_we); end
        end
        total++; if (icnt1 !== 16'd3 || bus1.mem_addr !== 32'h110 || wcnt1 !== 16'd4) begin
            bad++; $display("FAIL illegal_counts: got icnt=%0d addr=%h wcnt=%0d want 3 110 4", icnt1, bus1.mem_addr, wcnt1); end
        m_il = 3;
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] w;
        logic [2:0] fn;
        logic ii;
        logic [4:0] d, s1, s2;
        logic [11:0] im;
        int k;
        for (int n = 0; n < 60; n++) begin
            fn = 3'($urandom_range(0, 7)); ii = 1'($urandom); d = 5'($urandom); s1 = 5'($urandom);
            s2 = 5'($urandom); im = 12'($urandom);
            set_req(fn, ii, d, s1, s2, im);
            ref_encode(fn, ii, d, s1, s2, im, ok, w);
            bus1.in_valid = 1;
            if ($urandom_range(0, 4) == 0) begin
                load_base1 = 1; base1 = $urandom;
                #1;
                total++; if (bus1.in_ready !== 1'b0) begin bad++; $display("FAIL rnd_load_ready%0d: got %0h want 0", n, bus1.in_ready); end
                step();
                load_base1 = 0;
                m_addr = base1;
            end
            bus1.mem_ack = 1'($urandom);
            step();
            bus1.in_valid = 0;
            if (ok) begin
                total++; if (bus1.mem_we !== 1'b1 || bus1.mem_wdata !== w || bus1.mem_addr !== m_addr || illegal1 !== 1'b0) begin
                    bad++; $display("FAIL rnd_write%0d: got we=%0h data=%h addr=%h want we=1 data=%h addr=%h", n, bus1.mem_we, bus1.mem_wdata, bus1.mem_addr, w, m_addr); end
                bus1.mem_ack = 0;
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++) begin
                    step();
                    total++; if (bus1.mem_we !== 1'b1 || bus1.mem_wdata !== w) begin bad++; $display("FAIL rnd_hold%0d: got we=%0h data=%h want we=1 data=%h", n, bus1.mem_we, bus1.mem_wdata, w); end
                end
                bus1.mem_ack = 1;
                step();
                bus1.mem_ack = 0;
                m_addr = m_addr + 4; m_wr++;
                total++; if (bus1.mem_we !== 1'b0 || wcnt1 !== 16'(m_wr) || bus1.mem_addr !== m_addr) begin
                    bad++; $display("FAIL rnd_ack%0d: got we=%0h cnt=%0d addr=%h want we=0 cnt=%0d addr=%h", n, bus1.mem_we, wcnt1, bus1.mem_addr, m_wr, m_addr); end
            end else begin
                m_il++;
                total++; if (illegal1 !== 1'b1 || bus1.mem_we !== 1'b0 || icnt1 !== 16'(m_il) || bus1.mem_addr !== m_addr) begin
                    bad++; $display("FAIL rnd_illegal%0d: got ill=%0h we=%0h icnt=%0d addr=%h want 1 0 %0d %h", n, illegal1, bus1.mem_we, icnt1, bus1.mem_addr, m_il, m_addr); end
                bus1.mem_ack = 0;
                step();
            end
        end
    endtask

    task automatic test_wrap_and_saturate();
        logic [7:0] exp_addr [2] = '{8'hFC, 8'h00};
        load_base2 = 1; base2 = 8'hFC;
        step();
        load_base2 = 0;
        set_req(3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0);
        for (int i = 0; i < 9; i++) begin
            bus2.in_valid = 1;
            step();
            bus2.in_valid = 0;
            if (i < 2) begin
                total++; if (bus2.mem_we !== 1'b1 || bus2.mem_addr !== exp_addr[i]) begin
                    bad++; $display("FAIL wrap_addr%0d: got we=%0h addr=%h want we=1 addr=%h", i, bus2.mem_we, bus2.mem_addr, exp_addr[i]); end
            end
            bus2.mem_ack = 1;
            step();
            bus2.mem_ack = 0;
        end
        total++; if (wcnt2 !== 3'd7) begin bad++; $display("FAIL sat_written: got %0d want 7", wcnt2); end
        set_req(3'b110, 1'b0, 5'd1, 5'd1, 5'd1, 12'h0);
        for (int i = 0; i < 9; i++) begin
            bus2.in_valid = 1;
            step();
            bus2.in_valid = 0;
            step();
        end
        total++; if (icnt2 !== 3'd7) begin bad++; $display("FAIL sat_illegal: got %0d want 7", icnt2); end
    endtask

    task automatic test_reset_mid_write();
        set_req(3'b010, 1'b0, 5'd4, 5'd5, 5'd6, 12'h0);
        bus1.in_valid = 1;
        step();
        bus1.in_valid = 0;
        step();
        total++; if (bus1.mem_we !== 1'b1) begin bad++; $display("FAIL midrst_pre: got we=%0h want 1", bus1.mem_we); end
        rst1 = 1;
        step();
        rst1 = 0;
        #1;
        total++; if (bus1.mem_we !== 1'b0 || wcnt1 !== 16'd0 || icnt1 !== 16'd0 || bus1.mem_addr !== 32'h0 || bus1.in_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_post: got we=%0h w=%0d i=%0d addr=%h rdy=%0h want 0 0 0 0 1", bus1.mem_we, wcnt1, icnt1, bus1.mem_addr, bus1.in_ready); end
        bus1.mem_ack = 1;
        step();
        bus1.mem_ack = 0;
        total++; if (wcnt1 !== 16'd0 || bus1.mem_addr !== 32'h0) begin bad++; $display("FAIL midrst_ack_ignored: got cnt=%0d addr=%h want 0 0", wcnt1, bus1.mem_addr); end
    endtask

    initial begin
        rst1 = 1; rst2 = 1; load_base1 = 0; load_base2 = 0; base1 = '0; base2 = '0;
        bus1.in_valid = 0; bus1.mem_ack = 0; bus2.in_valid = 0; bus2.mem_ack = 0;
        set_req(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 12'h0);
        test_reset();
        test_load_and_add();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_random();
        test_wrap_and_saturate();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
